y86_memory_stage: RTL and testbench
===================================

Name: y86_memory_stage

Overview:
- Memory stage of the five-stage Y86-64 pipeline, between the M and W pipeline registers.
- Decodes M_icode into data-memory read/write controls and selects the address.
- Reads or writes a byte-addressed, little-endian 64-bit data memory.
- Produces m_valM for write-back and forwarding, and m_stat, the merged instruction status carried to W.

Parameters:
- DMEM_BYTES, 1024, data memory size in bytes; valid addresses are 0..DMEM_BYTES-1.
- ADDR_W, 64, address/data width; fixed at 64, parameter exists for readability only.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- M_icode  in  4  icode of instruction in M stage.
- M_valE  in  64  ALU result (address for rmmovq/mrmovq/call/pushq).
- M_valA  in  64  write data for stores; address for ret/popq.
- instr_valid  in  1  fetch reported a legal instruction.
- imem_error  in  1  fetch reported an instruction-memory address error.
- m_valM  out  64  data read from memory (combinational).
- m_stat  out  2  status: 0=AOK, 1=HLT, 2=ADR, 3=INS (combinational).

Behaviour:
- Read enable: icode 5 (mrmovq), 9 (ret), B (popq).
- Write enable: icode 4 (rmmovq), 8 (call), A (pushq).
- All other icodes (including 1 = nop/bubble): no access, m_valM=0.
- Address: M_valE for icodes 4, 5, 8, A; M_valA for icodes 9, B.
- Write data is always M_valA.
- Reads are combinational, same cycle, zero latency. m_valM = {mem[a+7],...,mem[a]} (little-endian).
- Writes commit on the rising clock edge, bytes a..a+7, little-endian.
- A read in the cycle after a write to the same address returns the new data.
- dmem_error: asserted when a read or write is enabled and a+7 >= DMEM_BYTES, with overflow-safe comparison (a > DMEM_BYTES-8 including 64-bit wrap).
- On dmem_error: no bytes are written and m_valM=0.
- m_stat priority:
  - ADR if dmem_error or imem_error;
  - else INS if !instr_valid;
  - else HLT if M_icode==0;
  - else AOK.
- Reset (reset_n=0, asynchronous): every memory byte is cleared to 0 immediately. While reset is held, writes are suppressed; m_valM therefore reads 0 and m_stat stays combinational.
- A write edge coinciding with reset assertion is dropped.
- The block holds no other state and has no handshake. Stall/bubble are handled by the surrounding pipeline registers; a bubble arrives as icode 1 and causes no access.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined: an enabled access with a[2:0] != 0 raises dmem_error, with the same effects as out-of-range (ADR, no write, m_valM=0).
- Undefined: unaligned accesses are legal and use the byte-wise little-endian semantics above.

Decomposition:
- Package y86_pkg:
  - icode constants: HALT=0, NOP=1, RRMOVQ=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B;
  - stat constants: AOK=0, HLT=1, ADR=2, INS=3;
  - RNONE=4'hF.
- One sub-module y86_dmem:
  - byte array with async-clear reset;
  - combinational 8-byte read port;
  - clocked 8-byte write port with enable;
  - range-error output.
- Control/address/stat decode lives in the top.

Test Plan:
- rmmovq store then load: icode 4, valE=0x100, valA=0x1122334455667788, one clock edge; then icode 5, valE=0x100 -> m_valM=0x1122334455667788 same cycle, m_stat=AOK; byte 0x100 holds 0x88.
- pushq/popq: icode A, valE=0x1F8, valA=0xDEAD, clock; icode B, valA=0x1F8 -> m_valM=0xDEAD. call at 0x3F0 with valA=0x40, then ret with valA=0x3F0 -> m_valM=0x40.
- Out of range: icode 4, valE=0x3FC, valA=0xFFFF -> m_stat=ADR and memory unchanged. icode 5, valE=0xFFFFFFFFFFFFFFFC -> m_valM=0, ADR.
- Status priority:
  - icode 0, instr_valid=1 -> HLT;
  - instr_valid=0 -> INS;
  - imem_error=1 with instr_valid=0 -> ADR;
  - icode 1 -> AOK, m_valM=0.
- Async reset: write 0x55 to 0x20, pull reset_n low mid-cycle -> read of 0x20 returns 0 before the next edge. A write attempted while reset_n=0 has no effect.
- With DMEM_ALIGN_CHECK_EN: icode 5, valE=0x101 -> ADR, m_valM=0. Without it, the same access returns the bytes 0x101..0x108.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: icode, status and register constants shared by the memory stage.
package y86_pkg;
  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] RRMOVQ = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;
  localparam logic [3:0] RNONE  = 4'hF;
  typedef enum logic [1:0] {AOK = 2'd0, HLT = 2'd1, ADR = 2'd2, INS = 2'd3} stat_t;
endpackage

// File: rtl/y86_dmem.sv
// y86_dmem: byte-addressed little-endian 64-bit data memory, async-clear, range error.
// DMEM_ALIGN_CHECK_EN additionally flags accesses not aligned to 8 bytes.
module y86_dmem #(
  parameter int DMEM_BYTES = 1024,
  parameter int ADDR_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic              rd_en,
  input  logic              wr_en,
  output logic [ADDR_W-1:0] rdata,
  output logic              err
);
  localparam int AW = $clog2(DMEM_BYTES);
  logic [7:0] mem [DMEM_BYTES];
  logic [AW-1:0] base;
  logic range_err;
  assign base = addr[AW-1:0];
  // a > DMEM_BYTES-8 catches a+7 overflowing the array and 64-bit wrap alike
  assign range_err = addr > ADDR_W'(DMEM_BYTES - 8);
`ifdef DMEM_ALIGN_CHECK_EN
  assign err = (rd_en || wr_en) && (range_err || addr[2:0] != 3'd0);
`else
  assign err = (rd_en || wr_en) && range_err;
`endif
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n)
      for (int i = 0; i < DMEM_BYTES; i++) mem[i] <= 8'h00;
    else if (wr_en && !err)
      for (int i = 0; i < 8; i++) mem[base + AW'(i)] <= wdata[8*i +: 8];
  always_comb begin
    rdata = '0;
    if (rd_en && !err)
      for (int i = 0; i < 8; i++) rdata[8*i +: 8] = mem[base + AW'(i)];
  end
endmodule

// File: rtl/y86_memory_stage.sv
// y86_memory_stage: Y86-64 M stage; decodes icode into memory access, produces m_valM and m_stat.
// Optional DMEM_ALIGN_CHECK_EN (in y86_dmem) makes unaligned accesses raise ADR.
module y86_memory_stage
  import y86_pkg::*;
#(
  parameter int DMEM_BYTES = 1024,
  parameter int ADDR_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [3:0]        M_icode,
  input  logic [ADDR_W-1:0] M_valE,
  input  logic [ADDR_W-1:0] M_valA,
  input  logic              instr_valid,
  input  logic              imem_error,
  output logic [ADDR_W-1:0] m_valM,
  output logic [1:0]        m_stat
);
  logic rd_en, wr_en, dmem_error;
  logic [ADDR_W-1:0] addr;
  assign rd_en = M_icode == MRMOVQ || M_icode == RET || M_icode == POPQ;
  assign wr_en = M_icode == RMMOVQ || M_icode == CALL || M_icode == PUSHQ;
  // ret/popq address through the stack pointer carried in valA
  assign addr = (M_icode == RET || M_icode == POPQ) ? M_valA : M_valE;
  assign m_stat = (dmem_error || imem_error) ? ADR :
                  !instr_valid               ? INS :
                  M_icode == HALT            ? HLT : AOK;
  y86_dmem #(.DMEM_BYTES(DMEM_BYTES), .ADDR_W(ADDR_W)) u_dmem (
    .clock(clock),
    .reset_n(reset_n),
    .addr(addr),
    .wdata(M_valA),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .rdata(m_valM),
    .err(dmem_error)
  );
endmodule

// File: tb/tb_y86_memory_stage.sv
// tb_y86_memory_stage: directed self-checking bench for the Y86-64 memory stage.
module tb_y86_memory_stage;
  logic clock = 1'b0;
  logic reset_n;
  logic [3:0] M_icode;
  logic [63:0] M_valE, M_valA;
  logic instr_valid, imem_error;
  logic [63:0] m_valM;
  logic [1:0] m_stat;
  int checks = 0;
  int errors = 0;

  y86_memory_stage dut (
    .clock(clock),
    .reset_n(reset_n),
    .M_icode(M_icode),
    .M_valE(M_valE),
    .M_valA(M_valA),
    .instr_valid(instr_valid),
    .imem_error(imem_error),
    .m_valM(m_valM),
    .m_stat(m_stat)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a);
    M_icode = ic;
    M_valE = e;
    M_valA = a;
    #1;
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset;
    drive(4'h5, 64'h0, 64'h0);
    checks++;
    if (m_valM !== 64'h0) begin errors++; $display("FAIL reset_valM got %h exp %h", m_valM, 64'h0); end
    checks++;
    if (m_stat !== 2'd0) begin errors++; $display("FAIL reset_stat got %0d exp %0d", m_stat, 0); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_store_load;
    drive(4'h4, 64'h100, 64'h1122334455667788);
    checks++;
    if (m_stat !== 2'd0) begin errors++; $display("FAIL store_stat got %0d exp %0d", m_stat, 0); end
    tick;
    drive(4'h5, 64'h100, 64'h0);
    checks++;
    if (m_valM !== 64'h1122334455667788) begin errors++; $display("FAIL load_valM got %h exp %h", m_valM, 64'h1122334455667788); end
    checks++;
    if (m_stat !== 2'd0) begin errors++; $display("FAIL load_stat got %0d exp %0d", m_stat, 0); end
  endtask

  task automatic test_unaligned;
    logic [63:0] exp_fd, exp_101;
    logic [1:0] exp_st;
`ifdef DMEM_ALIGN_CHECK_EN
    exp_fd = 64'h0; exp_101 = 64'h0; exp_st = 2'd2;
`else
    exp_fd = 64'h4455667788000000; exp_101 = 64'h0011223344556677; exp_st = 2'd0;
`endif
    drive(4'h5, 64'hFD, 64'h0);
    checks++;
    if (m_valM !== exp_fd) begin errors++; $display("FAIL unaligned_fd got %h exp %h", m_valM, exp_fd); end
    drive(4'h5, 64'h101, 64'h0);
    checks++;
    if (m_valM !== exp_101) begin errors++; $display("FAIL unaligned_101 got %h exp %h", m_valM, exp_101); end
    checks++;
    if (m_stat !== exp_st) begin errors++; $display("FAIL unaligned_stat got %0d exp %0d", m_stat, exp_st); end
  endtask

  task automatic test_push_pop;
    drive(4'hA, 64'h1F8, 64'hDEAD);
    tick;
    drive(4'hB, 64'h0, 64'h1F8);
    checks++;
    if (m_valM !== 64'hDEAD) begin errors++; $display("FAIL popq_valM got %h exp %h", m_valM, 64'hDEAD); end
    drive(4'h8, 64'h3F0, 64'h40);
    tick;
    drive(4'h9, 64'h0, 64'h3F0);
    checks++;
    if (m_valM !== 64'h40) begin errors++; $display("FAIL ret_valM got %h exp %h", m_valM, 64'h40); end
    checks++;
    if (m_stat !== 2'd0) begin errors++; $display("FAIL ret_stat got %0d exp %0d", m_stat, 0); end
  endtask

  task automatic test_out_of_range;
    drive(4'h4, 64'h3FC, 64'hFFFF);
    checks++;
    if (m_stat !== 2'd2) begin errors++; $display("FAIL oor_store_stat got %0d exp %0d", m_stat, 2); end
    tick;
    drive(4'h5, 64'h3F8, 64'h0);
    checks++;
    if (m_valM !== 64'h0) begin errors++; $display("FAIL oor_unchanged got %h exp %h", m_valM, 64'h0); end
    checks++;
    if (m_stat !== 2'd0) begin errors++; $display("FAIL last_word_stat got %0d exp %0d", m_stat, 0); end
    drive(4'h5, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
    checks++;
    if (m_valM !== 64'h0) begin errors++; $display("FAIL wrap_valM got %h exp %h", m_valM, 64'h0); end
    checks++;
    if (m_stat !== 2'd2) begin errors++; $display("FAIL wrap_stat got %0d exp %0d", m_stat, 2); end
    drive(4'h9, 64'h0, 64'h3F9);
    checks++;
    if (m_stat !== 2'd2) begin errors++; $display("FAIL ret_3f9_stat got %0d exp %0d", m_stat, 2); end
  endtask

  task automatic test_status;
    drive(4'h0, 64'h0, 64'h0);
    checks++;
    if (m_stat !== 2'd1) begin errors++; $display("FAIL halt_stat got %0d exp %0d", m_stat, 1); end
    instr_valid = 1'b0;
    #1;
    checks++;
    if (m_stat !== 2'd3) begin errors++; $display("FAIL ins_stat got %0d exp %0d", m_stat, 3); end
    imem_error = 1'b1;
    #1;
    checks++;
    if (m_stat !== 2'd2) begin errors++; $display("FAIL imem_stat got %0d exp %0d", m_stat, 2); end
    instr_valid = 1'b1;
    imem_error = 1'b0;
    drive(4'h1, 64'h100, 64'h100);
    checks++;
    if (m_stat !== 2'd0) begin errors++; $display("FAIL nop_stat got %0d exp %0d", m_stat, 0); end
    checks++;
    if (m_valM !== 64'h0) begin errors++; $display("FAIL nop_valM got %h exp %h", m_valM, 64'h0); end
  endtask

  task automatic test_back_to_back;
    drive(4'h4, 64'h200, 64'hAAAA_0000_0000_0001);
    tick;
    drive(4'h4, 64'h200, 64'hBBBB_0000_0000_0002);
    tick;
    drive(4'h5, 64'h200, 64'h0);
    checks++;
    if (m_valM !== 64'hBBBB_0000_0000_0002) begin errors++; $display("FAIL b2b_valM got %h exp %h", m_valM, 64'hBBBB_0000_0000_0002); end
  endtask

  task automatic test_async_reset;
    drive(4'h4, 64'h20, 64'h55);
    tick;
    drive(4'h5, 64'h20, 64'h0);
    checks++;
    if (m_valM !== 64'h55) begin errors++; $display("FAIL pre_reset_valM got %h exp %h", m_valM, 64'h55); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (m_valM !== 64'h0) begin errors++; $display("FAIL async_clear got %h exp %h", m_valM, 64'h0); end
    drive(4'h4, 64'h20, 64'h77);
    tick;
    drive(4'h5, 64'h20, 64'h0);
    reset_n = 1'b1;
    #1;
    checks++;
    if (m_valM !== 64'h0) begin errors++; $display("FAIL write_in_reset got %h exp %h", m_valM, 64'h0); end
    checks++;
    if (m_stat !== 2'd0) begin errors++; $display("FAIL post_reset_stat got %0d exp %0d", m_stat, 0); end
  endtask

  initial begin
    reset_n = 1'b0;
    instr_valid = 1'b1;
    imem_error = 1'b0;
    drive(4'h1, 64'h0, 64'h0);
    test_reset;
    test_store_load;
    test_unaligned;
    test_push_pop;
    test_out_of_range;
    test_status;
    test_back_to_back;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
